// File: rtl/down_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_timer_pkg
// Shared definitions for the loadable down-counting interval timer.
//   DT_W        : default counter / load-value width
//   DT_ALL_ONES : largest legal load value at the default width
//   dt_state_e  : timer FSM states (idle / counting)
// -----------------------------------------------------------------------------
package down_timer_pkg;

  localparam int unsigned DT_W = 8;

  localparam logic [DT_W-1:0] DT_ALL_ONES = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dt_state_e;

endpackage

// File: rtl/down_timer.sv
// -----------------------------------------------------------------------------
// down_timer
// Loadable down-counting interval timer. A programmed value is counted down to
// zero; expiry is flagged with a registered one-cycle done pulse.
//
// Optional build macro:
//   DOWN_TIMER_AUTO_RELOAD_EN - at expiry the count is reloaded from the value
//                               last loaded and the timer keeps running, giving
//                               a periodic done pulse until stop/load/reset.
//
// Ports:
//   clk      in  1  system clock, rising edge
//   reset    in  1  synchronous active-high reset
//   load     in  1  capture load_val into count (and reload register)
//   load_val in  w  interval length N, unsigned
//   start    in  1  begin counting from the current count
//   pause    in  1  hold the count while running
//   stop     in  1  abort a running interval without done
//   count    out w  current remaining count
//   busy     out 1  high while running
//   done     out 1  one-cycle pulse at interval expiry
//
// Input priority on each edge: reset > load > stop > start > pause.
// -----------------------------------------------------------------------------
module down_timer
  import down_timer_pkg::*;
#(
  parameter int unsigned w = DT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [w-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         stop,
  output logic [w-1:0] count,
  output logic         busy,
  output logic         done
);

  dt_state_e    r_state;
  dt_state_e    w_state_nxt;
  logic [w-1:0] r_count;
  logic [w-1:0] w_count_nxt;
  logic         r_done;
  logic         w_done_nxt;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [w-1:0] r_reload;
  logic [w-1:0] w_reload_nxt;
`endif

  // ---- state register ------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_done   <= w_done_nxt;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      r_reload <= w_reload_nxt;
`endif
    end
  end

  // ---- next-state / datapath -------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_done_nxt   = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    w_reload_nxt = r_reload;
`endif

    if (load) begin
      w_state_nxt  = ST_IDLE;
      w_count_nxt  = load_val;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      w_reload_nxt = load_val;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            // A zero-length interval expires immediately without running.
            if (r_count == '0) w_done_nxt  = 1'b1;
            else               w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_state_nxt = ST_IDLE;
          end else if (!pause) begin
            if (r_count == w'(1)) begin
              w_done_nxt  = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
              w_count_nxt = r_reload;
`else
              w_count_nxt = '0;
              w_state_nxt = ST_IDLE;
`endif
            end else if (r_count != '0) begin
              // Guard keeps the counter from wrapping below zero.
              w_count_nxt = r_count - w'(1);
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign count = r_count;
  assign busy  = (r_state == ST_RUN);
  assign done  = r_done;

endmodule
